// File: rtl/prog_clock_divider_pkg.sv
// Shared defaults and helpers for the programmable multi-channel clock divider.
package prog_clock_divider_pkg;

    localparam int DEF_NUM_CH  = 2;
    localparam int DEF_CNT_W   = 14;
    localparam int DEF_RST_DIV = 9999;

    // Width of a channel index; a single channel still needs one select bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prog_clock_divider_div_channel.sv
// One divider channel: wrap counter, shadowed terminal count and registered outputs.
module div_channel
    import prog_clock_divider_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int RST_DIV = DEF_RST_DIV
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pend,
    output logic             clk_out,
    output logic             tick,
    output logic [1:0]       phase
);

    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RST_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_sh;
    logic             wrap;

    assign wrap = en && (cnt == div_act);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= wrap;
            if (wrap) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
            end else if (en) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // The shadow is promoted only at a wrap, so every period runs to completion
    // under one divisor. A write can only arrive while pend is low, so the
    // promotion at this wrap never sees a divisor written in the same cycle.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_act <= RST_VAL;
            div_sh  <= RST_VAL;
            pend    <= 1'b0;
        end else begin
            if (wrap && pend) begin
                div_act <= div_sh;
                pend    <= 1'b0;
            end
            if (wr) begin
                div_sh <= wr_div;
                pend   <= 1'b1;
            end
        end
    end

    generate
        if (CNT_W >= 2) begin : g_phase_wide
            assign phase = cnt[1:0];
        end else begin : g_phase_narrow
            assign phase = {1'b0, cnt[0]};
        end
    endgenerate

endmodule

// File: rtl/prog_clock_divider.sv
// Programmable divider: NUM_CH independent channels sharing one divisor-write port.
module prog_clock_divider
    import prog_clock_divider_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int RST_DIV = DEF_RST_DIV
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         en,
    input  logic                      cfg_valid,
    input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]          cfg_div,
    output logic                      cfg_ready,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         tick,
    output logic [2*NUM_CH-1:0]       phase
);

    localparam int CH_W = ch_w(NUM_CH);

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] wr;

    // Handshake: a write transfers on a cycle where cfg_valid and cfg_ready are
    // both high. cfg_ready is combinational from cfg_ch and is low while that
    // channel still holds an unapplied divisor or when cfg_ch names no channel.
    always_comb begin
        cfg_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend[i];
            end
        end
    end

    always_comb begin
        wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        end
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            div_channel #(
                .CNT_W   (CNT_W),
                .RST_DIV (RST_DIV)
            ) u_ch (
                .clk_in  (clk_in),
                .rst     (rst),
                .en      (en[i]),
                .wr      (wr[i]),
                .wr_div  (cfg_div),
                .pend    (pend[i]),
                .clk_out (clk_out[i]),
                .tick    (tick[i]),
                .phase   (phase[2*i +: 2])
            );
        end
    endgenerate

endmodule

// File: tb/tb_prog_clock_divider.sv
// Randomised scoreboard bench for prog_clock_divider against a period-level model.
module tb_prog_clock_divider;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 14;
    localparam int RST_DIV = 9999;
    localparam int W       = 4 * NUM_CH;

    logic                clk_in;
    logic                rst;
    logic [NUM_CH-1:0]   en;
    logic                cfg_valid;
    logic [0:0]          cfg_ch;
    logic [CNT_W-1:0]    cfg_div;
    logic                cfg_ready;
    logic [NUM_CH-1:0]   clk_out;
    logic [NUM_CH-1:0]   tick;
    logic [2*NUM_CH-1:0] phase;

    prog_clock_divider #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .RST_DIV (RST_DIV)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .phase     (phase)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic         rdy_q[$];

    // Model: each channel is "left" enabled cycles away from its wrap, runs
    // periods of the divisor "div", and holds at most one queued divisor.
    int   m_left [NUM_CH];
    int   m_div  [NUM_CH];
    int   m_next [NUM_CH];
    logic m_lvl  [NUM_CH];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_left[i] = RST_DIV;
            m_div[i]  = RST_DIV;
            m_next[i] = -1;
            m_lvl[i]  = 1'b0;
        end
    endtask

    // driver: apply one cycle of inputs and push what the DUT must show
    task automatic drive_cycle(input logic r, input logic [NUM_CH-1:0] e,
                               input logic v, input int c, input int d);
        logic [NUM_CH-1:0]   x_clk;
        logic [NUM_CH-1:0]   x_tick;
        logic [2*NUM_CH-1:0] x_ph;
        logic                x_rdy;
        @(negedge clk_in);
        rst       = r;
        en        = e;
        cfg_valid = v;
        cfg_ch    = 1'(c);
        cfg_div   = CNT_W'(d);
        x_tick    = '0;
        if (r) begin
            model_reset();
            x_rdy = 1'b1;
        end else begin
            x_rdy = (c < NUM_CH) && (m_next[c] < 0);
            for (int i = 0; i < NUM_CH; i++) begin
                if (e[i]) begin
                    if (m_left[i] == 0) begin
                        m_lvl[i]  = ~m_lvl[i];
                        x_tick[i] = 1'b1;
                        if (m_next[i] >= 0) begin
                            m_div[i]  = m_next[i];
                            m_next[i] = -1;
                        end
                        m_left[i] = m_div[i];
                    end else begin
                        m_left[i] = m_left[i] - 1;
                    end
                end
            end
            if (v && x_rdy) m_next[c] = d;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            x_clk[i]       = m_lvl[i];
            x_ph[2*i +: 2] = 2'(m_div[i] - m_left[i]);
        end
        rdy_q.push_back(x_rdy);
        exp_q.push_back({x_clk, x_tick, x_ph});
    endtask

    // monitor: registered outputs just after each edge, cfg_ready mid-cycle
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (exp_q.size() > 0) check("outputs", {clk_out, tick, phase}, exp_q.pop_front());
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            #2;
            if (rdy_q.size() > 0) check("cfg_ready", W'(cfg_ready), W'(rdy_q.pop_front()));
        end
    end

    int first_tick;

    initial begin
        rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        model_reset();
        repeat (3) drive_cycle(1'b1, 2'b00, 1'b0, 0, 0);

        // first wrap after release lands RST_DIV+1 enabled cycles later
        first_tick = -1;
        for (int k = 1; k <= RST_DIV + 100; k++) begin
            drive_cycle(1'b0, 2'b11, 1'b0, 0, 0);
            @(posedge clk_in);
            #2;
            if (tick[0] === 1'b1) begin
                first_tick = k;
                break;
            end
        end
        check("first_tick", W'(first_tick), W'(RST_DIV + 1));

        // mid-period writes: ch0 -> 3, ch1 -> 0, then wait through the wrap
        repeat (2) drive_cycle(1'b0, 2'b11, 1'b0, 0, 0);
        drive_cycle(1'b0, 2'b11, 1'b1, 0, 3);
        drive_cycle(1'b0, 2'b11, 1'b1, 0, 7);
        drive_cycle(1'b0, 2'b11, 1'b1, 1, 0);
        repeat (RST_DIV + 20) drive_cycle(1'b0, 2'b11, 1'b0, 0, 0);

        // write ch0 in its exact wrap cycle
        for (int k = 0; k < 8 && m_left[0] != 0; k++) drive_cycle(1'b0, 2'b11, 1'b0, 0, 0);
        drive_cycle(1'b0, 2'b11, 1'b1, 0, 5);
        repeat (30) drive_cycle(1'b0, 2'b11, 1'b0, 0, 0);

        // freeze ch0 for 7 cycles mid-count
        repeat (3) drive_cycle(1'b0, 2'b11, 1'b0, 0, 0);
        repeat (7) drive_cycle(1'b0, 2'b10, 1'b0, 0, 0);
        repeat (30) drive_cycle(1'b0, 2'b11, 1'b0, 0, 0);

        // reset while a ch0 write is pending
        drive_cycle(1'b0, 2'b11, 1'b1, 0, 2);
        repeat (2) drive_cycle(1'b0, 2'b11, 1'b0, 0, 0);
        repeat (2) drive_cycle(1'b1, 2'b11, 1'b0, 0, 0);

        // randomised traffic
        for (int k = 0; k < 12000; k++) begin
            logic [NUM_CH-1:0] re;
            for (int i = 0; i < NUM_CH; i++) re[i] = ($urandom_range(0, 7) != 0);
            drive_cycle(1'b0, re, ($urandom_range(0, 3) == 0),
                        $urandom_range(0, NUM_CH - 1), $urandom_range(0, 9));
        end

        @(posedge clk_in);
        #3;
        check("queues_drained", W'(exp_q.size() + rdy_q.size()), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent divider channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 14: counter and divisor width per channel.
REQ-003 SHALL have parameter RST_DIV, default 9999: terminal count loaded into every channel at reset (10 MHz in gives 500 Hz out).
REQ-004 SHALL have port clk_in  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  NUM_CH  per-channel count enable.
REQ-007 SHALL have port cfg_valid  input  1  divisor-write request.
REQ-008 SHALL have port cfg_ch  input  max(1,$clog2(NUM_CH))  target channel of the write.
REQ-009 SHALL have port cfg_div  input  CNT_W  new terminal count.
REQ-010 SHALL have port cfg_ready  output  1  write can be accepted for cfg_ch.
REQ-011 SHALL have port clk_out  output  NUM_CH  divided 50%-duty clocks, registered.
REQ-012 SHALL have port tick  output  NUM_CH  one-cycle pulse per channel wrap, registered.
REQ-013 SHALL have port phase  output  2*NUM_CH  counter bits [1:0] of channel i on phase[2i+1:2i].

Function
REQ-014 Each channel SHALL keep counter cnt and active terminal count div_act; with en[i]=1, cnt increments by 1 per cycle until cnt==div_act, then cnt<=0 on the next edge.
REQ-015 On a wrap cycle (en[i]=1 and cnt==div_act), clk_out[i] SHALL toggle and tick[i] SHALL be 1 for exactly the following cycle; otherwise tick[i]=0.
REQ-016 Output period SHALL be 2*(div_act+1) clk_in cycles; div_act=0 SHALL give clk_out toggling every cycle and tick continuously high.
REQ-017 With en[i]=0, cnt, clk_out[i], div_act and any pending write SHALL hold; tick[i] SHALL be 0.
REQ-018 cfg_ready SHALL be combinational, equal to NOT pend[cfg_ch]; cfg_ch >= NUM_CH SHALL give cfg_ready=0 and no write.
REQ-019 A write SHALL be accepted when cfg_valid and cfg_ready are both 1: cfg_div goes into shadow register div_sh[cfg_ch], and pend[cfg_ch] is set.
REQ-020 On a wrap cycle with pend[i]=1, div_act<=div_sh and pend[i] cleared, so the new divisor governs the next period (glitch-free: no partial period).
REQ-021 Write accepted in the same cycle as a wrap on that channel SHALL NOT apply at that wrap; it applies at the following wrap.
REQ-022 New divisor smaller or larger than current cnt SHALL be harmless, since the change takes effect only at wrap with cnt=0.
REQ-023 Channels SHALL be fully independent; a write to channel j SHALL not disturb channel k.

Reset
REQ-024 While rst=1: cnt=0, div_act=div_sh=RST_DIV, pend=0, clk_out=0, tick=0, phase=0, cfg_ready=1 for valid cfg_ch.
REQ-025 Reset asserted mid-period or with a write pending SHALL discard the pending write; the first wrap after release occurs RST_DIV+1 enabled cycles later.

Structure
REQ-026 Package prog_clock_divider_pkg SHALL hold the default NUM_CH, CNT_W and RST_DIV constants and the channel-index width function.
REQ-027 Sub-module div_channel (one counter, shadow, pending flag, clk_out/tick registers) SHALL be instantiated NUM_CH times via generate; the top holds only the cfg decode and the cfg_ready mux.

Verification
REQ-028 Reset release, en=2'b11, RST_DIV=9999 -> first tick[0] in cycle 10001 after release; clk_out[0] period 20000 cycles.
REQ-029 Write ch0 div=3 mid-period -> cfg_ready low until next wrap; then clk_out[0] period 8 cycles, phase[1:0] sequence 0,1,2,3,0.
REQ-030 Write ch1 div=0 -> clk_out[1] toggles every cycle, tick[1] stays high, ch0 unchanged.
REQ-031 cfg_valid on ch0 in the exact wrap cycle with div=5 -> old period completes once more, then period 12.
REQ-032 en[0] low for 7 cycles mid-count -> cnt, clk_out[0] frozen, tick[0]=0; the period extends by exactly 7 cycles.
REQ-033 rst pulsed with ch0 pending div=2 -> pending lost, div_act=9999, cfg_ready=1 immediately.
